// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Multi-port integer register file with an issue-side scoreboard and a
//   post-reset clear sequencer. Entry 0 is hardwired to zero.
//
//   After reset the block spends NREGS cycles in INIT, clearing one entry per
//   cycle. While in INIT, writes, reservations and flushes are ignored, and all
//   read ports return 0 / not-busy. It then moves to RUN and stays there.
//
// Ports
//   i_clk       clock, rising edge
//   i_rstn      asynchronous reset, active low
//   i_flush     clear every pending bit
//   i_set_en    reserve destination i_set_id (marks it pending)
//   i_set_id    register being reserved
//   i_wen       per-port write enable          (NWR)
//   i_wid       per-port write index           (port k at [k*IDX +: IDX])
//   i_wdata     per-port write data            (port k at [k*XLEN +: XLEN])
//   i_rd_id     per-port read index            (port p at [p*IDX +: IDX])
//   o_rd_data   per-port read data, combinational
//   o_rd_busy   per-port: source register still pending
//   o_ready     high once the clear sequence has finished
//
// FSM states
//   ST_INIT | clearing the array, one entry per cycle; all inputs ignored
//   ST_RUN  | normal operation until the next reset

module reg_file_sb #(
    parameter  int XLEN   = 64,
    parameter  int NREGS  = 32,
    parameter  int NRD    = 4,
    parameter  int NWR    = 2,
    parameter  int BYPASS = 1,
    localparam int IDX    = $clog2(NREGS)
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_flush,
    input  logic                 i_set_en,
    input  logic [IDX-1:0]       i_set_id,
    input  logic [NWR-1:0]       i_wen,
    input  logic [NWR*IDX-1:0]   i_wid,
    input  logic [NWR*XLEN-1:0]  i_wdata,
    input  logic [NRD*IDX-1:0]   i_rd_id,
    output logic [NRD*XLEN-1:0]  o_rd_data,
    output logic [NRD-1:0]       o_rd_busy,
    output logic                 o_ready
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX-1:0]   r_cnt;
    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;
    logic [XLEN-1:0]  r_mem [NREGS];
    logic             w_run;

    // ---------------- sequencer ----------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = (r_state == ST_RUN);
        if (r_state == ST_INIT && r_cnt == IDX'(NREGS - 1)) begin
            w_state_nxt = ST_RUN;
        end
    end

    assign o_ready = w_run;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (!w_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ---------------- register array ----------------
    // No reset on the array: contents are cleared by the INIT walk instead.
    // Ports are visited in ascending order so the highest port's NBA lands
    // last and wins on an index collision.
    always_ff @(posedge i_clk) begin
        if (!w_run) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (i_wen[k] && i_wid[k*IDX +: IDX] != '0) begin
                    r_mem[i_wid[k*IDX +: IDX]] <= i_wdata[k*XLEN +: XLEN];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    // Write-clears are applied before the set so a new producer reserved in
    // the same cycle as an older result's writeback stays pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_run) begin
            if (i_flush) begin
                w_pend_nxt = '0;
            end else begin
                for (int k = 0; k < NWR; k++) begin
                    if (i_wen[k]) begin
                        w_pend_nxt[i_wid[k*IDX +: IDX]] = 1'b0;
                    end
                end
                if (i_set_en) begin
                    w_pend_nxt[i_set_id] = 1'b1;
                end
            end
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        logic [IDX-1:0] v_id;
        v_id      = '0;
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            v_id = i_rd_id[p*IDX +: IDX];
            if (w_run && v_id != '0) begin
                o_rd_data[p*XLEN +: XLEN] = r_mem[v_id];
                o_rd_busy[p]              = r_pend[v_id];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NWR; k++) begin
                        if (i_wen[k] && i_wid[k*IDX +: IDX] == v_id) begin
                            o_rd_data[p*XLEN +: XLEN] = i_wdata[k*XLEN +: XLEN];
                            o_rd_busy[p]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int IDX   = 5;

    logic                clk = 1'b0;
    logic                rstn;
    logic                flush;
    logic                set_en;
    logic [IDX-1:0]      set_id;
    logic [NWR-1:0]      wen;
    logic [NWR*IDX-1:0]  wid;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*IDX-1:0]  rd_id;

    logic [NRD*XLEN-1:0] rd_data,    nb_rd_data;
    logic [NRD-1:0]      rd_busy,    nb_rd_busy;
    logic                ready,      nb_ready;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_set_en(set_en), .i_set_id(set_id),
        .i_wen(wen), .i_wid(wid), .i_wdata(wdata), .i_rd_id(rd_id),
        .o_rd_data(rd_data), .o_rd_busy(rd_busy), .o_ready(ready)
    );

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_nb (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_set_en(set_en), .i_set_id(set_id),
        .i_wen(wen), .i_wid(wid), .i_wdata(wdata), .i_rd_id(rd_id),
        .o_rd_data(nb_rd_data), .o_rd_busy(nb_rd_busy), .o_ready(nb_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // kind: 0 data, 1 busy, 2 ready (bypass instance); 3,4,5 same for no-bypass
    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];

    function automatic logic [63:0] observe(int kind, int p);
        case (kind)
            0:       return rd_data[p*XLEN +: XLEN];
            1:       return 64'(rd_busy[p]);
            2:       return 64'(ready);
            3:       return nb_rd_data[p*XLEN +: XLEN];
            4:       return 64'(nb_rd_busy[p]);
            default: return 64'(nb_ready);
        endcase
    endfunction

    task automatic push(string tag, int kind, int p, logic [63:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.port = p;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic exp_rd(string tag, int p, logic [63:0] d, logic b, logic [63:0] nd, logic nb);
        push({tag, ".data"},    0, p, d);
        push({tag, ".busy"},    1, p, 64'(b));
        push({tag, ".nb_data"}, 3, p, nd);
        push({tag, ".nb_busy"}, 4, p, 64'(nb));
    endtask

    task automatic exp_ready(string tag, logic r);
        push({tag, ".ready"},    2, 0, 64'(r));
        push({tag, ".nb_ready"}, 5, 0, 64'(r));
    endtask

    task automatic check();
        exp_t        e;
        logic [63:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind, e.port);
            checks++;
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s port%0d: observed %0h expected %0h", e.tag, e.port, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        flush  = 1'b0;
        set_en = 1'b0;
        set_id = '0;
        wen    = '0;
        wid    = '0;
        wdata  = '0;
        rd_id  = '0;
    endtask

    task automatic wr(int k, logic [IDX-1:0] id, logic [XLEN-1:0] d);
        wen[k]                = 1'b1;
        wid[k*IDX +: IDX]     = id;
        wdata[k*XLEN +: XLEN] = d;
    endtask

    task automatic rd(int p, logic [IDX-1:0] id);
        rd_id[p*IDX +: IDX] = id;
    endtask

    task automatic init_walk(string tag);
        for (int i = 0; i < NREGS; i++) begin
            idle();
            if (i == NREGS - 1) begin
                wr(0, 5'd10, 64'hDEAD);
                wr(1, 5'd11, 64'hBEEF);
                set_en = 1'b1;
                set_id = 5'd12;
                rd(0, 5'd10);
                exp_rd({tag, "_rd_in_init"}, 0, 64'h0, 1'b0, 64'h0, 1'b0);
            end
            exp_ready({tag, "_init"}, 1'b0);
            check();
            @(negedge clk);
        end
        idle();
        exp_ready({tag, "_run"}, 1'b1);
        check();
        for (int b = 0; b < NREGS / NRD; b++) begin
            idle();
            for (int p = 0; p < NRD; p++) begin
                rd(p, 5'(b * NRD + p));
                exp_rd({tag, "_zero_after_init"}, p, 64'h0, 1'b0, 64'h0, 1'b0);
            end
            check();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rstn = 1'b0;
        #12;
        exp_ready("in_reset", 1'b0);
        check();

        // 1. clear sequence
        @(negedge clk);
        rstn = 1'b1;
        init_walk("first");

        // 2. write collisions and x0
        @(negedge clk); idle();
        wr(0, 5'd5, 64'hAA); wr(1, 5'd5, 64'hBB); rd(0, 5'd5);
        exp_rd("same_wid_bypass", 0, 64'hBB, 1'b0, 64'h0, 1'b0);
        check();
        @(negedge clk); idle();
        wr(0, 5'd0, 64'hFF); rd(0, 5'd5); rd(1, 5'd0);
        exp_rd("same_wid_hi_wins", 0, 64'hBB, 1'b0, 64'hBB, 1'b0);
        exp_rd("x0_no_bypass",     1, 64'h0,  1'b0, 64'h0,  1'b0);
        check();
        @(negedge clk); idle();
        rd(1, 5'd0); wr(0, 5'd20, 64'h11); wr(1, 5'd21, 64'h22);
        exp_rd("x0_stays_zero", 1, 64'h0, 1'b0, 64'h0, 1'b0);
        check();
        @(negedge clk); idle();
        rd(0, 5'd20); rd(1, 5'd21);
        exp_rd("dual_write_p0", 0, 64'h11, 1'b0, 64'h11, 1'b0);
        exp_rd("dual_write_p1", 1, 64'h22, 1'b0, 64'h22, 1'b0);
        check();

        // 3. bypass
        @(negedge clk); idle();
        wr(0, 5'd7, 64'h1234); rd(0, 5'd7);
        exp_rd("bypass_same_cycle", 0, 64'h1234, 1'b0, 64'h0, 1'b0);
        check();
        @(negedge clk); idle();
        rd(0, 5'd7);
        exp_rd("write_next_cycle", 0, 64'h1234, 1'b0, 64'h1234, 1'b0);
        check();

        // 4. scoreboard set / clear
        @(negedge clk); idle();
        set_en = 1'b1; set_id = 5'd9; rd(2, 5'd9);
        exp_rd("set_not_yet", 2, 64'h0, 1'b0, 64'h0, 1'b0);
        check();
        @(negedge clk); idle();
        rd(2, 5'd9);
        exp_rd("busy_after_set", 2, 64'h0, 1'b1, 64'h0, 1'b1);
        check();
        @(negedge clk); idle();
        wr(1, 5'd9, 64'h99); rd(2, 5'd9);
        exp_rd("write_masks_busy", 2, 64'h99, 1'b0, 64'h0, 1'b1);
        check();
        @(negedge clk); idle();
        rd(2, 5'd9);
        exp_rd("pending_cleared", 2, 64'h99, 1'b0, 64'h99, 1'b0);
        check();
        @(negedge clk); idle();
        set_en = 1'b1; set_id = 5'd9; wr(0, 5'd9, 64'h55); rd(2, 5'd9);
        exp_rd("set_and_write", 2, 64'h55, 1'b0, 64'h99, 1'b0);
        check();
        @(negedge clk); idle();
        rd(2, 5'd9);
        exp_rd("set_beats_write", 2, 64'h55, 1'b1, 64'h55, 1'b1);
        check();

        // 5. flush beats a same-cycle set
        @(negedge clk); idle(); set_en = 1'b1; set_id = 5'd3;
        @(negedge clk); idle(); set_en = 1'b1; set_id = 5'd4;
        @(negedge clk); idle(); set_en = 1'b1; set_id = 5'd6;
        @(negedge clk); idle();
        rd(0, 5'd3); rd(1, 5'd4); rd(2, 5'd6); rd(3, 5'd9);
        exp_rd("pend3", 0, 64'h0,  1'b1, 64'h0,  1'b1);
        exp_rd("pend4", 1, 64'h0,  1'b1, 64'h0,  1'b1);
        exp_rd("pend6", 2, 64'h0,  1'b1, 64'h0,  1'b1);
        exp_rd("pend9", 3, 64'h55, 1'b1, 64'h55, 1'b1);
        check();
        @(negedge clk); idle();
        flush = 1'b1; set_en = 1'b1; set_id = 5'd8;
        rd(0, 5'd3); rd(1, 5'd4); rd(2, 5'd6); rd(3, 5'd8);
        exp_rd("flush_same_cycle", 0, 64'h0, 1'b1, 64'h0, 1'b1);
        exp_rd("set8_same_cycle",  3, 64'h0, 1'b0, 64'h0, 1'b0);
        check();
        @(negedge clk); idle();
        rd(0, 5'd3); rd(1, 5'd4); rd(2, 5'd6); rd(3, 5'd8);
        for (int p = 0; p < NRD; p++) begin
            exp_rd("after_flush", p, 64'h0, 1'b0, 64'h0, 1'b0);
        end
        check();
        @(negedge clk); idle();
        rd(3, 5'd9);
        exp_rd("after_flush9", 3, 64'h55, 1'b0, 64'h55, 1'b0);
        check();

        // 6. reset in the middle of RUN
        @(negedge clk); idle(); set_en = 1'b1; set_id = 5'd3;
        @(negedge clk); idle(); set_en = 1'b1; set_id = 5'd11;
        @(negedge clk); idle();
        rd(0, 5'd3); rd(1, 5'd11);
        exp_rd("pre_reset3",  0, 64'h0,    1'b1, 64'h0,    1'b1);
        exp_rd("pre_reset11", 1, 64'h0,    1'b1, 64'h0,    1'b1);
        exp_ready("pre_reset", 1'b1);
        check();
        rstn = 1'b0;
        exp_ready("reset_drop", 1'b0);
        exp_rd("reset_busy", 0, 64'h0, 1'b0, 64'h0, 1'b0);
        check();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        init_walk("second");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
